// File: rtl/mem_port_arbiter.sv
// Two-requester round-robin arbiter for a picorv32-style valid/ready memory port.
// Downstream request and upstream response are registered; a watchdog faults hung accesses.
module mem_port_arbiter #(
  parameter int TIMEOUT = 255,
  parameter int CNT_W   = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        s0_valid,
  input  logic        s0_instr,
  input  logic [31:0] s0_addr,
  input  logic [31:0] s0_wdata,
  input  logic [3:0]  s0_wstrb,
  output logic        s0_ready,
  output logic [31:0] s0_rdata,
  output logic        s0_fault,
  input  logic        s1_valid,
  input  logic        s1_instr,
  input  logic [31:0] s1_addr,
  input  logic [31:0] s1_wdata,
  input  logic [3:0]  s1_wstrb,
  output logic        s1_ready,
  output logic [31:0] s1_rdata,
  output logic        s1_fault,
  output logic        mem_valid,
  output logic        mem_instr,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wstrb,
  input  logic        mem_ready,
  input  logic [31:0] mem_rdata,
  output logic        grant,
  output logic        busy,
  output logic [1:0]  dbg_state
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT - 1);

  state_t           state, state_next;
  logic [CNT_W-1:0] cnt;
  logic             last_served;
  logic             sel_load;
  logic             sel_port;
  logic             done_ok;
  logic             done_fault;

  // Handshake: a requester holds valid until its one-cycle ready pulse;
  // downstream, mem_valid stays high in BUSY until mem_ready or watchdog expiry.
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    sel_load   = 1'b0;
    sel_port   = 1'b0;
    done_ok    = 1'b0;
    done_fault = 1'b0;
    case (state)
      IDLE: begin
        if (s0_valid || s1_valid) begin
          sel_load   = 1'b1;
          sel_port   = (s0_valid && s1_valid) ? ~last_served : s1_valid;
          state_next = BUSY;
        end
      end
      BUSY: begin
        // Ready wins over a watchdog expiry in the same cycle.
        if (mem_ready) begin
          done_ok    = 1'b1;
          state_next = RESP;
        end else if ((TIMEOUT != 0) && (cnt == LIMIT)) begin
          done_fault = 1'b1;
          state_next = RESP;
        end
      end
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      mem_valid   <= 1'b0;
      mem_instr   <= 1'b0;
      mem_addr    <= '0;
      mem_wdata   <= '0;
      mem_wstrb   <= '0;
      grant       <= 1'b0;
      cnt         <= '0;
      last_served <= 1'b1;
      s0_ready    <= 1'b0;
      s0_rdata    <= '0;
      s0_fault    <= 1'b0;
      s1_ready    <= 1'b0;
      s1_rdata    <= '0;
      s1_fault    <= 1'b0;
    end else begin
      s0_ready <= 1'b0;
      s0_fault <= 1'b0;
      s1_ready <= 1'b0;
      s1_fault <= 1'b0;
      if (sel_load) begin
        mem_valid <= 1'b1;
        mem_instr <= sel_port ? s1_instr : s0_instr;
        mem_addr  <= sel_port ? s1_addr  : s0_addr;
        mem_wdata <= sel_port ? s1_wdata : s0_wdata;
        mem_wstrb <= sel_port ? s1_wstrb : s0_wstrb;
        grant     <= sel_port;
        cnt       <= '0;
      end
      if (state == BUSY && !done_ok && !done_fault) cnt <= cnt + 1'b1;
      if (done_ok || done_fault) begin
        mem_valid   <= 1'b0;
        last_served <= grant;
        if (grant == 1'b0) begin
          s0_ready <= 1'b1;
          s0_fault <= done_fault;
          s0_rdata <= done_ok ? mem_rdata : 32'd0;
        end else begin
          s1_ready <= 1'b1;
          s1_fault <= done_fault;
          s1_rdata <= done_ok ? mem_rdata : 32'd0;
        end
      end
    end
  end

  assign busy      = (state != IDLE);
  assign dbg_state = state;

endmodule
